hls_ap_ctrl_host: RTL and testbench

- Host-side initiator for the ap_ctrl_hs block-level protocol used by the HLS compute blocks, e.g. hls_macc_motion.
- Holds ten 32-bit operand registers, loaded over a simple write port, and drives them onto the accelerator in1..in10.
- Runs one start/ready/done transaction, captures out1..out3 on their ap_vld strobes, and returns the results to the host with a valid/ready handshake, plus a timeout guard and a run counter.

---
 rtl/hls_ap_ctrl_host.sv | 114 +++++++++++
 tb/tb_hls_ap_ctrl_host.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_ap_ctrl_host.sv
// Host-side ap_ctrl_hs initiator: operand bank, one start/ready/done run,
// result capture on ap_vld strobes, valid/ready return, timeout guard.
module hls_ap_ctrl_host #(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 10,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [DATA_W-1:0]      cfg_wdata,
  input  logic                   cmd_go,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_out1,
  output logic [DATA_W-1:0]      res_out2,
  output logic [DATA_W-1:0]      res_out3,
  output logic [2:0]             res_vld_mask,
  output logic                   res_timeout,
  output logic [CNT_W-1:0]       run_count,
  output logic                   acc_ap_start,
  input  logic                   acc_ap_done,
  input  logic                   acc_ap_idle,
  input  logic                   acc_ap_ready,
  output logic [N_IN*DATA_W-1:0] acc_in,
  input  logic [DATA_W-1:0]      acc_out1,
  input  logic [DATA_W-1:0]      acc_out2,
  input  logic [DATA_W-1:0]      acc_out3,
  input  logic                   acc_out1_ap_vld,
  input  logic                   acc_out2_ap_vld,
  input  logic                   acc_out3_ap_vld
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_HOLD} state_t;

  state_t                        r_state, w_next;
  logic [N_IN-1:0][DATA_W-1:0]   r_op;
  logic [2:0][DATA_W-1:0]        r_res;
  logic [2:0]                    r_mask;
  logic                          r_timeout;
  logic [CNT_W-1:0]              r_tcnt, r_runs;
  logic                          w_accept, w_run, w_expire;
  logic [2:0][DATA_W-1:0]        w_acc_out;
  logic [2:0]                    w_vld;
  logic                          w_unused;

  // Idle status is informational only; start never waits on it.
  assign w_unused  = acc_ap_idle;
  assign w_acc_out = {acc_out3, acc_out2, acc_out1};
  assign w_vld     = {acc_out3_ap_vld, acc_out2_ap_vld, acc_out1_ap_vld};
  assign w_accept  = (r_state == S_IDLE) && cmd_go;
  assign w_run     = (r_state == S_START) || (r_state == S_WAIT_DONE);
  assign w_expire  = (TIMEOUT != 0) && (r_tcnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (cmd_go) w_next = S_START;
      S_START: begin
        if (acc_ap_done || w_expire) w_next = S_HOLD;
        else if (acc_ap_ready)       w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (acc_ap_done || w_expire) w_next = S_HOLD;
      S_HOLD:      if (res_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_res     <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
      r_tcnt    <= '0;
      r_runs    <= '0;
    end else begin
      r_state <= w_next;
      for (int k = 0; k < N_IN; k++)
        if ((r_state == S_IDLE) && cfg_we && (cfg_addr == 4'(k))) r_op[k] <= cfg_wdata;
      if (w_accept) begin
        r_mask    <= '0;
        r_timeout <= 1'b0;
        r_tcnt    <= '0;
      end else if (w_run) begin
        r_tcnt <= r_tcnt + 1'b1;
        for (int k = 0; k < 3; k++)
          if (w_vld[k]) begin
            r_res[k]  <= w_acc_out[k];
            r_mask[k] <= 1'b1;
          end
        // Done in the expiry cycle counts as a normal completion.
        if (acc_ap_done)   r_runs    <= r_runs + 1'b1;
        else if (w_expire) r_timeout <= 1'b1;
      end
    end
  end

  assign acc_in       = r_op;
  assign acc_ap_start = (r_state == S_START);
  assign busy         = (r_state != S_IDLE);
  assign res_valid    = (r_state == S_HOLD);
  assign res_out1     = r_res[0];
  assign res_out2     = r_res[1];
  assign res_out3     = r_res[2];
  assign res_vld_mask = r_mask;
  assign res_timeout  = r_timeout;
  assign run_count    = r_runs;

endmodule

// File: tb/tb_hls_ap_ctrl_host.sv
// Randomized bench for hls_ap_ctrl_host: timeline-based accelerator model and
// an outcome model computed from ready/done/strobe schedules.
module tb_hls_ap_ctrl_host;
  localparam int DW = 32, NI = 10, TO = 8, CW = 16, PL = 16;

  logic ap_clk = 1'b0, ap_rst_n;
  logic cfg_we, cmd_go, res_ready, acc_ap_done, acc_ap_idle, acc_ap_ready;
  logic [3:0] cfg_addr;
  logic [DW-1:0] cfg_wdata, acc_out1, acc_out2, acc_out3;
  logic acc_out1_ap_vld, acc_out2_ap_vld, acc_out3_ap_vld;
  logic busy, res_valid, res_timeout, acc_ap_start;
  logic [DW-1:0] res_out1, res_out2, res_out3;
  logic [2:0] res_vld_mask;
  logic [CW-1:0] run_count;
  logic [NI*DW-1:0] acc_in;

  logic b_go, b_rr, b_busy, b_valid, b_to, b_start;
  logic [DW-1:0] b_o1, b_o2, b_o3;
  logic [2:0] b_mask;
  logic [1:0] b_cnt;
  logic [NI*DW-1:0] b_in;

  hls_ap_ctrl_host #(.DATA_W(DW), .N_IN(NI), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cmd_go(cmd_go), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_out1(res_out1), .res_out2(res_out2), .res_out3(res_out3),
    .res_vld_mask(res_vld_mask), .res_timeout(res_timeout), .run_count(run_count),
    .acc_ap_start(acc_ap_start), .acc_ap_done(acc_ap_done), .acc_ap_idle(acc_ap_idle),
    .acc_ap_ready(acc_ap_ready), .acc_in(acc_in), .acc_out1(acc_out1), .acc_out2(acc_out2),
    .acc_out3(acc_out3), .acc_out1_ap_vld(acc_out1_ap_vld), .acc_out2_ap_vld(acc_out2_ap_vld),
    .acc_out3_ap_vld(acc_out3_ap_vld));

  // Second instance: 2-bit run counter, no timeout, instantly-done accelerator.
  hls_ap_ctrl_host #(.DATA_W(DW), .N_IN(NI), .TIMEOUT(0), .CNT_W(2)) u_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_we(1'b0), .cfg_addr(4'd0),
    .cfg_wdata('0), .cmd_go(b_go), .busy(b_busy), .res_valid(b_valid),
    .res_ready(b_rr), .res_out1(b_o1), .res_out2(b_o2), .res_out3(b_o3),
    .res_vld_mask(b_mask), .res_timeout(b_to), .run_count(b_cnt),
    .acc_ap_start(b_start), .acc_ap_done(1'b1), .acc_ap_idle(1'b1),
    .acc_ap_ready(1'b1), .acc_in(b_in), .acc_out1('0), .acc_out2('0),
    .acc_out3('0), .acc_out1_ap_vld(1'b0), .acc_out2_ap_vld(1'b0),
    .acc_out3_ap_vld(1'b0));

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m_op [NI];
  logic [DW-1:0] m_res [3];
  logic [2:0] m_mask;
  logic m_to;
  int m_cnt;
  bit p_vld [3][PL];
  logic [DW-1:0] p_val [3][PL];

  task automatic chk(input string tag, input logic [NI*DW-1:0] got, input logic [NI*DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NI*DW-1:0] m_pack();
    logic [NI*DW-1:0] v;
    for (int k = 0; k < NI; k++) v[k*DW +: DW] = m_op[k];
    return v;
  endfunction

  task automatic step();
    @(posedge ap_clk); #1;
  endtask

  task automatic clr_acc();
    acc_ap_ready = 0; acc_ap_done = 0;
    acc_out1_ap_vld = 0; acc_out2_ap_vld = 0; acc_out3_ap_vld = 0;
  endtask

  task automatic cfg_write(input int addr, input logic [DW-1:0] data);
    cfg_we = 1; cfg_addr = 4'(addr); cfg_wdata = data;
    step();
    cfg_we = 0;
    if (addr < NI) m_op[addr] = data;
  endtask

  task automatic plan_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < PL; i++) begin p_vld[k][i] = 0; p_val[k][i] = '0; end
  endtask

  task automatic plan_rand();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < PL; i++) begin
        p_vld[k][i] = ($urandom_range(0, 3) == 0);
        p_val[k][i] = $urandom;
      end
  endtask

  // R/D: START-relative cycle index of the ready/done pulse, -1 for never.
  task automatic do_run(input int R, input int D);
    bit norm;
    int endi, i, st_cyc, bz_cyc, nbp;
    norm = (D >= 0) && (D < TO);
    endi = norm ? D : TO - 1;
    chk("acc_in_pre", acc_in, m_pack());
    m_mask = 0; m_to = 0;
    cmd_go = 1; step(); cmd_go = 0;
    i = 0; st_cyc = 0; bz_cyc = 0;
    while (!res_valid && i < 64) begin
      if (acc_ap_start) st_cyc++;
      if (busy) bz_cyc++;
      acc_ap_ready = (i == R);
      acc_ap_done  = (i == D);
      acc_ap_idle  = 1'($urandom);
      acc_out1_ap_vld = (i < PL) ? p_vld[0][i] : 1'b0; acc_out1 = (i < PL) ? p_val[0][i] : '0;
      acc_out2_ap_vld = (i < PL) ? p_vld[1][i] : 1'b0; acc_out2 = (i < PL) ? p_val[1][i] : '0;
      acc_out3_ap_vld = (i < PL) ? p_vld[2][i] : 1'b0; acc_out3 = (i < PL) ? p_val[2][i] : '0;
      if (i <= endi && i < PL)
        for (int k = 0; k < 3; k++)
          if (p_vld[k][i]) begin m_res[k] = p_val[k][i]; m_mask[k] = 1'b1; end
      cmd_go = ($urandom_range(0, 3) == 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = 4'($urandom_range(0, NI - 1)); cfg_wdata = $urandom;
      step(); i++;
    end
    clr_acc(); cmd_go = 0; cfg_we = 0;
    if (norm) m_cnt++;
    m_to = !norm;
    chk("done_to_valid", i, endi + 1);
    chk("start_cycles", st_cyc, (R >= 0 && R < endi) ? R + 1 : endi + 1);
    chk("busy_cycles", bz_cyc, endi + 1);
    chk("start_in_hold", acc_ap_start, 0);
    chk("res_out1", res_out1, m_res[0]);
    chk("res_out2", res_out2, m_res[1]);
    chk("res_out3", res_out3, m_res[2]);
    chk("res_mask", res_vld_mask, m_mask);
    chk("res_timeout", res_timeout, m_to);
    chk("run_count", run_count, m_cnt[CW-1:0]);
    // Backpressure with ignored strobes, writes and go pulses.
    nbp = $urandom_range(0, 10);
    for (int j = 0; j < nbp; j++) begin
      acc_out1_ap_vld = 1; acc_out1 = $urandom;
      acc_out2_ap_vld = 1'($urandom); acc_out2 = $urandom;
      acc_ap_done = 1'($urandom);
      cmd_go = 1'($urandom); cfg_we = 1; cfg_addr = 4'd2; cfg_wdata = $urandom;
      step();
    end
    clr_acc(); cmd_go = 0; cfg_we = 0;
    chk("hold_valid", res_valid, 1);
    chk("hold_out1", res_out1, m_res[0]);
    chk("hold_out2", res_out2, m_res[1]);
    chk("hold_mask", res_vld_mask, m_mask);
    chk("acc_in_hold", acc_in, m_pack());
    res_ready = 1; step(); res_ready = 0;
    chk("post_valid", res_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int R, D, nw;
    ap_rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cmd_go = 0; res_ready = 0;
    acc_ap_idle = 0; acc_out1 = 0; acc_out2 = 0; acc_out3 = 0; clr_acc();
    b_go = 0; b_rr = 0;
    for (int k = 0; k < NI; k++) m_op[k] = '0;
    for (int k = 0; k < 3; k++) m_res[k] = '0;
    m_mask = 0; m_to = 0; m_cnt = 0;
    #12;
    chk("rst_start", acc_ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", run_count, 0);
    chk("rst_out1", res_out1, 0);
    chk("rst_mask", res_vld_mask, 0);
    chk("rst_to", res_timeout, 0);
    chk("rst_acc_in", acc_in, 0);
    @(negedge ap_clk); ap_rst_n = 1;
    step();

    // Directed: ready on 3rd START cycle, done + all strobes 5 cycles later
    // (lands exactly on the timeout expiry cycle, done must win).
    for (int k = 0; k < NI; k++) cfg_write(k, DW'(k + 1));
    plan_clear();
    for (int k = 0; k < 3; k++) begin p_vld[k][7] = 1; p_val[k][7] = DW'(32'h11 * (k + 1)); end
    do_run(2, 7);
    chk("dir_out1", res_out1, 32'h11);
    chk("dir_mask", res_vld_mask, 3'b111);
    chk("dir_count", run_count, 1);

    // Combinational accelerator: ready/done/out2 strobe on the first START cycle.
    plan_clear(); p_vld[1][0] = 1; p_val[1][0] = 32'hABCD;
    do_run(0, 0);
    chk("comb_mask", res_vld_mask, 3'b010);
    chk("comb_out1_kept", res_out1, 32'h11);

    // Timeout and done-before-ready.
    plan_rand(); do_run(1, -1);
    chk("to_flag", res_timeout, 1);
    chk("to_count", run_count, 2);
    plan_rand(); do_run(5, 2);

    // Out-of-range write in IDLE is ignored (checked at next run's acc_in).
    cfg_write(12, 32'hDEAD_BEEF);
    plan_rand(); do_run(-1, 4);

    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, 15), $urandom);
      R = $urandom_range(0, 9);
      D = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 10);
      plan_rand();
      do_run(R, D);
    end

    // Reset in WAIT_DONE.
    cmd_go = 1; step(); cmd_go = 0;
    acc_ap_ready = 1; step(); acc_ap_ready = 0;
    step();
    chk("mid_busy_pre", busy, 1);
    ap_rst_n = 0; #1;
    chk("mid_start", acc_ap_start, 0);
    chk("mid_busy", busy, 0);
    chk("mid_valid", res_valid, 0);
    chk("mid_count", run_count, 0);
    for (int k = 0; k < NI; k++) m_op[k] = '0;
    for (int k = 0; k < 3; k++) m_res[k] = '0;
    m_cnt = 0;
    @(negedge ap_clk); ap_rst_n = 1;
    step();
    plan_rand(); do_run(1, 3);

    // Run counter wrap on the 2-bit instance.
    for (int r = 1; r <= 4; r++) begin
      int w;
      b_go = 1; step(); b_go = 0;
      w = 0;
      while (!b_valid && w < 10) begin step(); w++; end
      chk("wrap_valid", b_valid, 1);
      chk("wrap_count", b_cnt, r % 4);
      b_rr = 1; step(); b_rr = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
